// File: rtl/msg_sequencer.sv
// Steps gen_char through a stored message of up to 16 codes, emitting 5 glyph columns
// plus GAP_COLS blank columns per character, one column per tick; stop aborts immediately.
module msg_sequencer #(
  parameter int GAP_COLS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [4:0] msg_len,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  input  logic       tick,
  input  logic [6:0] gen_col,
  input  logic       gen_finish,
  output logic [3:0] caracter_code,
  output logic [3:0] counter,
  output logic [6:0] col_data,
  output logic       col_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, LOAD, EMIT, GAP, ADV} state_t;

  localparam logic [2:0] GAP_W = 3'(GAP_COLS);

  state_t     state, state_n;
  logic [3:0] mem [16];
  logic [3:0] idx, idx_n;
  logic [4:0] len, len_n;
  logic [2:0] gap_cnt, gap_n;
  logic [3:0] code_n, cnt_n;
  logic [6:0] cd_n;
  logic       cv_n, done_n;
  logic       last;

  // Message storage is deliberately not reset so a reset mid-playback keeps the text.
  always_ff @(posedge clk) begin
    if (!rst && wr_en && state == IDLE) mem[wr_addr] <= wr_data;
  end

  assign busy = (state != IDLE);
  assign last = ({1'b0, idx} == (len - 5'd1));

  always_comb begin
    state_n = state;
    code_n  = caracter_code;
    cnt_n   = counter;
    cd_n    = col_data;
    cv_n    = 1'b0;
    done_n  = 1'b0;
    idx_n   = idx;
    len_n   = len;
    gap_n   = gap_cnt;
    if (stop && state != IDLE) begin
      state_n = IDLE;
      cnt_n   = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start && msg_len != 5'd0 && msg_len <= 5'd16) begin
            len_n   = msg_len;
            idx_n   = 4'd0;
            state_n = LOAD;
          end
        end
        LOAD: begin
          code_n  = mem[idx];
          cnt_n   = 4'd0;
          state_n = EMIT;
        end
        EMIT: begin
          if (gen_finish) begin
            cnt_n = 4'd0;
            gap_n = 3'd0;
            if (GAP_COLS == 0) begin
              state_n = ADV;
            end else begin
              state_n = GAP;
              // A tick landing on the finish cycle already counts as the first spacer.
              if (tick) begin
                cd_n  = 7'd0;
                cv_n  = 1'b1;
                gap_n = 3'd1;
              end
            end
          end else if (tick) begin
            cd_n  = gen_col;
            cv_n  = 1'b1;
            cnt_n = (counter == 4'd5) ? counter : counter + 4'd1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W) begin
            state_n = ADV;
          end else if (tick) begin
            cd_n  = 7'd0;
            cv_n  = 1'b1;
            gap_n = gap_cnt + 3'd1;
          end
        end
        ADV: begin
          if (last && loop) begin
            idx_n   = 4'd0;
            state_n = LOAD;
          end else if (last) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            idx_n   = idx + 4'd1;
            state_n = LOAD;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      caracter_code <= 4'd0;
      counter       <= 4'd0;
      col_data      <= 7'd0;
      col_valid     <= 1'b0;
      done          <= 1'b0;
      idx           <= 4'd0;
      len           <= 5'd0;
      gap_cnt       <= 3'd0;
    end else begin
      state         <= state_n;
      caracter_code <= code_n;
      counter       <= cnt_n;
      col_data      <= cd_n;
      col_valid     <= cv_n;
      done          <= done_n;
      idx           <= idx_n;
      len           <= len_n;
      gap_cnt       <= gap_n;
    end
  end

endmodule

// File: tb/tb_msg_sequencer.sv
// Directed bench for msg_sequencer; a trivial gen_char stand-in returns {code, counter[2:0]}.
module tb_msg_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = 4'd0;
  logic [3:0] wr_data = 4'd0;
  logic [4:0] msg_len = 5'd0;
  logic       start = 1'b0, start2 = 1'b0;
  logic       stop = 1'b0;
  logic       loop = 1'b0;
  logic       tick = 1'b0, tick2 = 1'b0;

  logic [3:0] caracter_code, counter, code2, cnt2;
  logic [6:0] col_data, cd2, gen_col, gen_col2;
  logic       col_valid, busy, done, cv2, busy2, done2;
  logic       gen_finish, fin2;

  assign gen_col    = {caracter_code, counter[2:0]};
  assign gen_finish = (counter == 4'd5);
  assign gen_col2   = {code2, cnt2[2:0]};
  assign fin2       = (cnt2 == 4'd5);

  msg_sequencer #(.GAP_COLS(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .start(start), .stop(stop), .loop(loop), .tick(tick),
    .gen_col(gen_col), .gen_finish(gen_finish), .caracter_code(caracter_code),
    .counter(counter), .col_data(col_data), .col_valid(col_valid), .busy(busy), .done(done)
  );

  msg_sequencer #(.GAP_COLS(2)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .start(start2), .stop(stop), .loop(loop), .tick(tick2),
    .gen_col(gen_col2), .gen_finish(fin2), .caracter_code(code2),
    .counter(cnt2), .col_data(cd2), .col_valid(cv2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [6:0] col_q[$];
  logic [6:0] col2_q[$];
  logic [3:0] code_q[$];
  logic [3:0] prev_code = 4'hx;
  int         done_cnt = 0;
  int         done2_cnt = 0;

  always @(negedge clk) begin
    if (col_valid === 1'b1) col_q.push_back(col_data);
    if (cv2 === 1'b1) col2_q.push_back(cd2);
    if (done === 1'b1) done_cnt++;
    if (done2 === 1'b1) done2_cnt++;
    if (caracter_code !== prev_code) begin
      code_q.push_back(caracter_code);
      prev_code = caracter_code;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic write(input logic [3:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic go(input logic [4:0] l, input logic lp);
    msg_len = l; loop = lp; start = 1'b1;
    step();
    start = 1'b0;
    step(2);
  endtask

  task automatic go2(input logic [4:0] l, input logic lp);
    msg_len = l; loop = lp; start2 = 1'b1;
    step();
    start2 = 1'b0;
    step(2);
  endtask

  task automatic tk(input int n);
    repeat (n) begin
      tick = 1'b1; step(); tick = 1'b0; step(3);
    end
  endtask

  task automatic tk2(input int n);
    repeat (n) begin
      tick2 = 1'b1; step(); tick2 = 1'b0; step(3);
    end
  endtask

  int         cb, db, kb;
  logic [3:0] exp_codes [6];
  logic [6:0] obs_col;
  logic [3:0] obs_code;

  initial begin
    // Reset with random inputs, including a start that must be ignored.
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      wr_en = 1'($urandom); wr_addr = 4'($urandom); wr_data = 4'($urandom);
      tick = 1'($urandom); loop = 1'($urandom); stop = 1'($urandom);
      start = 1'b1; msg_len = 5'd1;
    end
    step();
    check("rst_busy", 32'(busy), 0);
    check("rst_code", 32'(caracter_code), 0);
    check("rst_counter", 32'(counter), 0);
    check("rst_col_data", 32'(col_data), 0);
    check("rst_col_valid", 32'(col_valid), 0);
    check("rst_done", 32'(done), 0);
    wr_en = 1'b0; tick = 1'b0; loop = 1'b0; stop = 1'b0; start = 1'b0; msg_len = 5'd0;
    rst = 1'b0;
    step(2);
    check("post_rst_busy", 32'(busy), 0);

    // Single character, one spacer column.
    write(4'd0, 4'd3);
    cb = col_q.size(); db = done_cnt;
    go(5'd1, 1'b0);
    check("single_busy", 32'(busy), 1);
    check("single_code", 32'(caracter_code), 3);
    tk(6);
    check("single_npulses", 32'(col_q.size() - cb), 6);
    for (int i = 0; i < 6; i++) begin
      obs_col = (cb + i < col_q.size()) ? col_q[cb + i] : 7'h7f;
      check($sformatf("single_col%0d", i), 32'(obs_col), (i < 5) ? 32'(24 + i) : 32'd0);
    end
    check("single_done", 32'(done_cnt - db), 1);
    check("single_busy_end", 32'(busy), 0);

    // Three characters with wrap.
    write(4'd0, 4'd1); write(4'd1, 4'd7); write(4'd2, 4'd10);
    exp_codes[0] = 4'd1; exp_codes[1] = 4'd7; exp_codes[2] = 4'd10;
    exp_codes[3] = 4'd1; exp_codes[4] = 4'd7; exp_codes[5] = 4'd10;
    kb = code_q.size(); db = done_cnt; cb = col_q.size();
    go(5'd3, 1'b1);
    tk(36);
    check("wrap_ncodes_ge6", 32'(code_q.size() - kb >= 6), 1);
    for (int i = 0; i < 6; i++) begin
      obs_code = (kb + i < code_q.size()) ? code_q[kb + i] : 4'hx;
      check($sformatf("wrap_code%0d", i), 32'(obs_code), 32'(exp_codes[i]));
    end
    check("wrap_npulses", 32'(col_q.size() - cb), 36);
    check("wrap_no_done", 32'(done_cnt - db), 0);
    check("wrap_busy", 32'(busy), 1);
    stop = 1'b1; step(); stop = 1'b0;
    check("wrap_stop_busy", 32'(busy), 0);

    // Stop mid-glyph coincident with a tick; a write while busy is dropped.
    write(4'd0, 4'd3);
    go(5'd1, 1'b0);
    tk(2);
    check("stop_counter_pre", 32'(counter), 2);
    write(4'd0, 4'd9);
    cb = col_q.size(); db = done_cnt;
    stop = 1'b1; tick = 1'b1;
    step();
    stop = 1'b0; tick = 1'b0;
    check("stop_col_valid", 32'(col_valid), 0);
    check("stop_busy", 32'(busy), 0);
    check("stop_counter", 32'(counter), 0);
    check("stop_done", 32'(done), 0);
    check("stop_code_hold", 32'(caracter_code), 3);
    step(3);
    check("stop_no_pulse", 32'(col_q.size() - cb), 0);
    check("stop_no_done", 32'(done_cnt - db), 0);
    go(5'd1, 1'b0);
    check("busy_write_dropped", 32'(caracter_code), 3);
    stop = 1'b1; step(); stop = 1'b0;

    // Illegal lengths.
    msg_len = 5'd0; start = 1'b1; step(); start = 1'b0; step(2);
    check("len0_busy", 32'(busy), 0);
    msg_len = 5'd17; start = 1'b1; step(); start = 1'b0; step(2);
    check("len17_busy", 32'(busy), 0);

    // Full 16-character message.
    for (int i = 0; i < 16; i++) write(4'(i), 4'(i));
    cb = col_q.size(); db = done_cnt; kb = code_q.size();
    go(5'd16, 1'b0);
    tk(96);
    check("len16_npulses", 32'(col_q.size() - cb), 96);
    check("len16_ncodes", 32'(code_q.size() - kb), 16);
    check("len16_last_code", 32'(code_q[$]), 15);
    check("len16_done", 32'(done_cnt - db), 1);
    check("len16_busy", 32'(busy), 0);

    // GAP_COLS=2, tick coincident with gen_finish.
    write(4'd0, 4'd3); write(4'd1, 4'd5);
    cb = col2_q.size(); db = done2_cnt;
    go2(5'd2, 1'b0);
    tk2(4);
    tick2 = 1'b1; step(); tick2 = 1'b0;
    check("coin_counter5", 32'(cnt2), 5);
    tick2 = 1'b1; step(); tick2 = 1'b0;
    check("coin_blank1_valid", 32'(cv2), 1);
    check("coin_blank1_data", 32'(cd2), 0);
    step(3);
    check("coin_wait_gap", 32'(code2), 3);
    tk2(1);
    check("coin_next_code", 32'(code2), 5);
    check("coin_npulses", 32'(col2_q.size() - cb), 7);
    for (int i = 0; i < 7; i++) begin
      obs_col = (cb + i < col2_q.size()) ? col2_q[cb + i] : 7'h7f;
      check($sformatf("coin_col%0d", i), 32'(obs_col), (i < 5) ? 32'(24 + i) : 32'd0);
    end
    check("coin_no_done", 32'(done2_cnt - db), 0);
    stop = 1'b1; step(); stop = 1'b0;
    check("coin_stop_busy", 32'(busy2), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
